// File: rtl/occupancy_counter.sv
// Saturating parking-lot occupancy counter with registered full/empty and sticky error flags.
// Define OCC_PEAK_EN to add the peak-occupancy output and register.
module occupancy_counter #(
  parameter int CAPACITY = 25,
  parameter int COUNT_W  = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               exit,
  input  logic               clr_err,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
`ifdef OCC_PEAK_EN
  ,
  output logic [COUNT_W-1:0] peak
`endif
);

  localparam logic [COUNT_W-1:0]   CAP_C = COUNT_W'(CAPACITY);
  localparam logic signed [COUNT_W+1:0] CAP_S = (COUNT_W + 2)'(CAPACITY);

  // Apply a -1/0/+1 step and clamp into 0..CAPACITY so the count never wraps.
  function automatic logic [COUNT_W-1:0] sat_step(input logic [COUNT_W-1:0] cur,
                                                  input logic signed [1:0] delta);
    logic signed [COUNT_W+1:0] sum;
    sum = $signed({2'b00, cur}) + delta;
    if (sum > CAP_S)
      sum = CAP_S;
    else if (sum < 0)
      sum = '0;
    return sum[COUNT_W-1:0];
  endfunction

  logic signed [1:0]  delta;
  logic [COUNT_W-1:0] cnt_nxt;
  logic               ovf_ev;
  logic               unf_ev;

  always_comb begin
    delta   = $signed({1'b0, enter}) - $signed({1'b0, exit});
    cnt_nxt = sat_step(count, delta);
    ovf_ev  = enter & ~exit & (count == CAP_C);
    unf_ev  = exit & ~enter & (count == '0);
  end

  // Register stage: every output is a flop, flags give set priority over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      full      <= (cnt_nxt == CAP_C);
      empty     <= (cnt_nxt == '0);
      overflow  <= ovf_ev | (overflow & ~clr_err);
      underflow <= unf_ev | (underflow & ~clr_err);
    end
  end

`ifdef OCC_PEAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      peak <= '0;
    else if (cnt_nxt > peak)
      peak <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench for occupancy_counter: directed scenarios plus a free-running
// reference model compared on every falling edge.
module tb_occupancy_counter;

  localparam int CAP = 25;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enter = 1'b0;
  logic          exit = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
`ifdef OCC_PEAK_EN
  logic [CW-1:0] peak;
`endif

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  int m_ovf = 0;
  int m_unf = 0;
  int m_peak = 0;

  occupancy_counter #(.CAPACITY(CAP), .COUNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .enter(enter),
    .exit(exit),
    .clr_err(clr_err),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .underflow(underflow)
`ifdef OCC_PEAK_EN
    ,
    .peak(peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic with clamping.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0; m_peak = 0;
    end else begin
      int n;
      bit ovf_ev, unf_ev;
      n = m_cnt + int'(enter) - int'(exit);
      ovf_ev = 0; unf_ev = 0;
      if (n > CAP) begin n = CAP; ovf_ev = 1; end
      if (n < 0)   begin n = 0;   unf_ev = 1; end
      m_cnt = n;
      m_ovf = (ovf_ev || (m_ovf != 0 && !clr_err)) ? 1 : 0;
      m_unf = (unf_ev || (m_unf != 0 && !clr_err)) ? 1 : 0;
      if (m_cnt > m_peak) m_peak = m_cnt;
    end
  end

  always @(negedge clk) begin
    check("model_count", int'(count), m_cnt);
    check("model_full", int'(full), (m_cnt == CAP) ? 1 : 0);
    check("model_empty", int'(empty), (m_cnt == 0) ? 1 : 0);
    check("model_overflow", int'(overflow), m_ovf);
    check("model_underflow", int'(underflow), m_unf);
`ifdef OCC_PEAK_EN
    check("model_peak", int'(peak), m_peak);
`endif
  end

  // One input cycle: drive just after an edge, return 1 time unit after the sampling edge.
  task automatic step(input logic e, input logic x, input logic c);
    enter = e; exit = x; clr_err = c;
    @(posedge clk); #1;
    enter = 1'b0; exit = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_unf", int'(underflow), 0);

    // Basic counting, back to back
    step(1, 0, 0); check("basic_c1", int'(count), 1);
    step(1, 0, 0); check("basic_c2", int'(count), 2);
    step(1, 0, 0); check("basic_c3", int'(count), 3);
    check("basic_empty", int'(empty), 0);
    check("basic_full", int'(full), 0);
`ifdef OCC_PEAK_EN
    check("basic_peak", int'(peak), 3);
`endif

    // Fill and overflow
    repeat (22) step(1, 0, 0);
    check("fill_count", int'(count), 25);
    check("fill_full", int'(full), 1);
    step(1, 0, 0);
    check("ovf_count", int'(count), 25);
    check("ovf_flag", int'(overflow), 1);
    step(0, 0, 1);
    check("ovf_clr", int'(overflow), 0);

    // Simultaneous at full
    step(1, 1, 0);
    check("sim_full_count", int'(count), 25);
    check("sim_full_ovf", int'(overflow), 0);
    check("sim_full_unf", int'(underflow), 0);

    // Underflow
    do_reset();
    step(0, 1, 0);
    check("unf_count", int'(count), 0);
    check("unf_empty", int'(empty), 1);
    check("unf_flag", int'(underflow), 1);
    step(0, 1, 1);
    check("unf_set_over_clr", int'(underflow), 1);
    step(0, 0, 1);
    check("unf_clr", int'(underflow), 0);
    step(1, 1, 0);
    check("sim_empty_count", int'(count), 0);
    check("sim_empty_unf", int'(underflow), 0);
    check("sim_empty_ovf", int'(overflow), 0);

    // Async reset mid-operation
    repeat (10) step(1, 0, 0);
    check("pre_rst_count", int'(count), 10);
    #2 reset = 1'b1;
    #1;
    check("async_count", int'(count), 0);
    check("async_empty", int'(empty), 1);
    step(1, 0, 0);
    check("rst_ignores_pulse", int'(count), 0);
    reset = 1'b0;
    step(1, 0, 0);
    check("post_rst_count", int'(count), 1);

    // Peak tracking
    do_reset();
    repeat (5) step(1, 0, 0);
    repeat (3) step(0, 1, 0);
`ifdef OCC_PEAK_EN
    check("peak_mid", int'(peak), 5);
`endif
    step(1, 0, 0);
    check("peak_final_count", int'(count), 3);
`ifdef OCC_PEAK_EN
    check("peak_final", int'(peak), 5);
`endif

    // Pseudo-random traffic biased towards the boundaries, checked by the model
    for (int i = 0; i < 400; i++) begin
      logic e, x, c;
      e = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
      x = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
      c = ($urandom_range(0, 19) == 0);
      step(e, x, c);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Tracks the number of cars inside the parking lot. Consumes the single-cycle `enter`/`exit` pulses produced by the car-detection FSM and maintains a saturating occupancy count with full/empty status and sticky error flags. Its registered outputs drive the lot's status display and the "lot full" indicator.

## Interface
- `CAPACITY`, default 25: maximum legal occupancy; must be ≥ 1.
- `COUNT_W`, default `$clog2(CAPACITY+1)` (5 for the default): width of the count outputs.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single system clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately, independent of `clk`.
- `enter`, in, 1: one-cycle pulse, one car entered; sampled on the rising edge of `clk`.
- `exit`, in, 1: one-cycle pulse, one car exited; sampled on the rising edge of `clk`.
- `clr_err`, in, 1: synchronous clear of the sticky error flags.
- `count`, out, COUNT_W: current occupancy, range 0..CAPACITY.
- `full`, out, 1: high when `count == CAPACITY`.
- `empty`, out, 1: high when `count == 0`.
- `overflow`, out, 1: sticky; an enter was seen while full.
- `underflow`, out, 1: sticky; an exit was seen while empty.
- `peak`, out, COUNT_W: highest `count` since reset. Present only with `OCC_PEAK_EN`.

## Operation
- **Reset values:** `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `peak`=0.
- **Per-edge update:** evaluate {`enter`, `exit`} on each edge.
  - 00: hold.
  - 10, not full: count+1.
  - 10, full: hold count, set `overflow`.
  - 01, not empty: count−1.
  - 01, empty: hold count, set `underflow`.
  - 11: net zero. Count is unchanged and no error flag is set, even at full or empty.
- **Saturation:** count never wraps. It stays within 0..CAPACITY at all times.
- **`full`/`empty`:** registered. They are derived from the next count value, so they are valid in the same cycle as the new `count`.
- **`clr_err`:** clears both sticky flags on the edge where it is sampled high.
  - If a new error event occurs on that same edge, the flag is set. Set has priority over clear.
- **`peak`:** on any edge where the next count exceeds `peak`, `peak` takes the next count.
- **Internal structure:** count register, two sticky flag registers, optional peak register. No other FSM state is needed.

## Timing
- **Latency:** a pulse sampled at edge N is reflected on `count`/`full`/`empty`/flags after edge N. That is one cycle after the pulse cycle.
- **Pulse rate:** back-to-back pulses on consecutive cycles must each be counted. There is no minimum spacing.
- **Input timing:** inputs may come from combinational (Mealy) logic of the upstream FSM. They must be stable at the rising edge, and no synchronizer is added here.
- **Reset mid-operation:** asserting `reset` at any time forces all outputs to their reset values asynchronously.
  - While `reset` is high, pulses are ignored.
  - The first edge after deassertion processes inputs normally.
- **All outputs are registered.** There is no combinational path from any input to any output.

## Configuration
- Macro `OCC_PEAK_EN`.
  - **Defined:** the `peak` output port and register exist, with the behaviour given in Operation.
  - **Not defined:** the `peak` port is absent from the port list, and no peak register is synthesized.
- All other behaviour is identical in both builds.

## Test plan
- **Basic counting:** reset, then 3 enter pulses on consecutive cycles. Expect `count` 1,2,3 after successive edges, `empty`=0, `full`=0; `peak`=3 if enabled.
- **Fill and overflow:** drive 25 enters. Expect `count`=25, `full`=1. Then one more enter: `count` stays 25 and `overflow`=1. Then `clr_err`: `overflow`=0 next cycle.
- **Underflow:** from reset, one exit. Expect `count`=0, `empty`=1, `underflow`=1.
  - Then `clr_err` and exit on the same edge: `underflow` remains 1.
- **Simultaneous events:** at count=25, drive `enter`=`exit`=1 for one cycle. Expect `count`=25 and no flags set.
  - Repeat at count=0: `count`=0 and no flags set.
- **Async reset mid-operation:** at count=10, assert `reset` between clock edges. Expect `count`=0, `empty`=1 before the next edge.
  - Pulses during reset are not counted.
  - After release, one enter: `count`=1.
- **Peak tracking (`OCC_PEAK_EN`):** 5 enters, then 3 exits, then 1 enter. Expect `peak`=5 throughout and a final `count`=3.
